cache_traffic_gen: RTL
======================

Name: cache_traffic_gen

Overview:
- Parametrised, self-checking CPU-side stimulus and statistics engine for the set-associative cache.
- Successor to the fixed address generator and hit/miss counters in the synthesis top: widths, gap, stride and pattern are configurable.
- Adds a bounded request count, a valid/ready handshake with one outstanding request, read/write mixing, a response timeout and saturating statistics.
- Sits between board controls (switches/LEDs) or a testbench and the cache CPU port.

Parameters:
ADDR_W, 20, CPU byte-address width
DATA_W, 32, CPU write-data width
CNT_W, 16, width of request/hit/miss counters and num_req
INTERVAL, 256, idle cycles between response and next request (>=1)
STRIDE, 256, byte stride for strided mode
XOR_MASK, 20'h55, mask for xor mode (ADDR_W bits)
TIMEOUT, 1024, max cycles waiting for a response

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; run request sequence
mode  in  2  00 seq, 01 strided, 10 xor, 11 LFSR
rw_mode  in  2  00 all read, 01 all write, 10 alternate R/W, 11 = 00
num_req  in  CNT_W  requests per run; 0 = run forever
cpu_req_valid  out  1  request valid
cpu_req_rw  out  1  1 = write
cpu_req_size  out  2  constant 2'd2 (word)
cpu_req_addr  out  ADDR_W  request address
cpu_req_wdata  out  DATA_W  write data
cpu_req_ready  in  1  cache accepts request
cpu_resp_valid  in  1  response strobe
cpu_resp_hit  in  1  response was hit
busy  out  1  run in progress
done  out  1  run finished
err  out  1  sticky timeout flag
req_cnt  out  CNT_W  completed requests
hit_cnt  out  CNT_W  hits, saturating
miss_cnt  out  CNT_W  misses, saturating

Behaviour:
- Reset: all outputs 0 except cpu_req_size = 2; FSM = IDLE; index i = 0; LFSR = 1.
- States: IDLE, GAP, ISSUE, WAIT_RESP, DONE.
- IDLE: when start = 1:
  - latch mode, rw_mode, num_req;
  - clear req_cnt, hit_cnt, miss_cnt, err, i;
  - load gap counter with INTERVAL-1; go to GAP. busy = 1 from the next cycle.
- GAP: decrement each cycle; at 0, drive the request and go to ISSUE.
- ISSUE: cpu_req_valid = 1.
  - addr, rw and wdata are registered and stable until cpu_req_valid && cpu_req_ready (same-cycle handshake).
  - On handshake: valid drops next cycle; go to WAIT_RESP; clear timeout counter.
- Address (all arithmetic mod 2^ADDR_W):
  - seq: i*4
  - strided: i*STRIDE
  - xor: (i*4) ^ XOR_MASK
  - LFSR: {lfsr[ADDR_W-3:0], 2'b00}, Fibonacci maximal-length LFSR, advanced once per issued request.
- rw per request: 0 (read), 1 (write), or i[0] (alternate).
- wdata: low DATA_W bits of {addr, ~addr}.
- WAIT_RESP: on cpu_resp_valid:
  - hit_cnt or miss_cnt +1, holding at all-ones when saturated;
  - req_cnt +1, wrapping;
  - i +1, wrapping.
  - If num_req != 0 and the new req_cnt == num_req, go to DONE; else reload the gap counter and go to GAP.
- Timeout: after TIMEOUT cycles in WAIT_RESP with no response, set err and go to DONE. req_cnt does not increment.
- DONE: busy = 0, done = 1. Stays in DONE while start = 1; start = 0 returns to IDLE with done cleared. Statistics hold until the next start.
- start deasserted in GAP or WAIT_RESP: the run continues to completion (num_req = 0: finishes the current request, then DONE).
- cpu_resp_valid outside WAIT_RESP is ignored.
- Response in the same cycle as the timeout expiry: the response wins; err is not set.
- Reset mid-run returns to the reset state immediately. cpu_req_valid drops asynchronously.

Optional Feature:
- Macro LATENCY_STATS_EN.
- Defined: adds outputs lat_last, lat_max (CNT_W) and lat_sum (2*CNT_W).
  - Latency = cycles from the cycle after the handshake to the response cycle, inclusive (response next cycle = 1).
  - All three cleared on start.
  - lat_max updates when greater; lat_sum saturates.
- Undefined: none of these ports or registers exist; all other behaviour is identical.

Test Plan:
- INTERVAL=4, mode=00, rw=00, num_req=3, cache model: ready=1, response 2 cycles after handshake, hit=1 -> addrs 0x0, 0x4, 0x8 all reads; hit_cnt=3, miss_cnt=0, req_cnt=3; done=1; exactly 4 idle cycles before each request.
- mode=01, STRIDE=256, rw=10, num_req=4, ready held low 3 cycles on the 2nd request -> addrs 0x000, 0x100, 0x200, 0x300; rw 0, 1, 0, 1; addr/wdata stable while stalled; wdata of 2nd = {0x00100, 0xFFEFF} truncated to 32 bits.
- mode=10, num_req=2 -> addrs 0x55, 0x51.
- CNT_W=4, num_req=0, all hits, 20 responses -> hit_cnt stays at 15, req_cnt wraps to 4.
- TIMEOUT=8, no response -> err=1 exactly 8 cycles after the handshake; done=1; req_cnt=0.
- rst_n low while in WAIT_RESP -> all outputs at reset values in the same cycle; a new start runs from i=0.
- LATENCY_STATS_EN with latencies 2, 5, 3 -> lat_last=3, lat_max=5, lat_sum=10.

Source files
------------

// File: rtl/cache_traffic_gen.sv
// CPU-side stimulus and statistics engine for the set-associative cache.
// Optional latency statistics are enabled with the LATENCY_STATS_EN macro.
module cache_traffic_gen #(
    parameter int unsigned       ADDR_W   = 20,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       CNT_W    = 16,
    parameter int unsigned       INTERVAL = 256,
    parameter int unsigned       STRIDE   = 256,
    parameter logic [ADDR_W-1:0] XOR_MASK = 'h55,
    parameter int unsigned       TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [1:0]        rw_mode,
    input  logic [CNT_W-1:0]  num_req,
    output logic              cpu_req_valid,
    output logic              cpu_req_rw,
    output logic [1:0]        cpu_req_size,
    output logic [ADDR_W-1:0] cpu_req_addr,
    output logic [DATA_W-1:0] cpu_req_wdata,
    input  logic              cpu_req_ready,
    input  logic              cpu_resp_valid,
    input  logic              cpu_resp_hit,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  req_cnt,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
`ifdef LATENCY_STATS_EN
    ,
    output logic [CNT_W-1:0]   lat_last,
    output logic [CNT_W-1:0]   lat_max,
    output logic [2*CNT_W-1:0] lat_sum
`endif
);

    localparam int unsigned       GAP_W    = $clog2(INTERVAL + 1);
    localparam int unsigned       TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0]  GapLoad  = GAP_W'(INTERVAL - 1);
    localparam logic [TO_W-1:0]   ToLast   = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] StrideA  = ADDR_W'(STRIDE);
    // Maximal-length tap sets for common widths; other widths fall back to a non-maximal pair.
    localparam logic [63:0] TapsAll =
        (ADDR_W == 8)  ? 64'hB8 :
        (ADDR_W == 10) ? 64'h240 :
        (ADDR_W == 12) ? 64'h829 :
        (ADDR_W == 16) ? 64'hD008 :
        (ADDR_W == 20) ? 64'h90000 :
        (ADDR_W == 24) ? 64'hE10000 :
        (ADDR_W == 32) ? 64'h80200003 :
        ((64'd1 << (ADDR_W - 1)) | 64'd1);
    localparam logic [ADDR_W-1:0] LfsrTaps = ADDR_W'(TapsAll);

    typedef enum logic [2:0] {StIdle, StGap, StIssue, StWaitResp, StDone} state_e;

    state_e            state_q;
    logic [1:0]        mode_q;
    logic [1:0]        rw_mode_q;
    logic [CNT_W-1:0]  num_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] lfsr_q;
    logic [GAP_W-1:0]  gap_q;
    logic [TO_W-1:0]   to_q;

    logic [ADDR_W-1:0]   next_addr;
    logic [ADDR_W-1:0]   lfsr_next;
    logic                next_rw;
    logic [2*ADDR_W-1:0] addr_cat;
    logic [DATA_W-1:0]   next_wdata;
    logic [CNT_W-1:0]    req_cnt_inc;
    logic                run_end;

    assign cpu_req_size = 2'd2;
    assign lfsr_next    = {lfsr_q[ADDR_W-2:0], ^(lfsr_q & LfsrTaps)};
    assign addr_cat     = {next_addr, ~next_addr};
    assign next_wdata   = DATA_W'(addr_cat);
    assign req_cnt_inc  = req_cnt + CNT_W'(1);
    // Free-running runs end after the current request once start is released.
    assign run_end      = (num_q != '0) ? (req_cnt_inc == num_q) : !start;

    always_comb begin
        next_addr = '0;
        case (mode_q)
            2'b00:   next_addr = {idx_q[ADDR_W-3:0], 2'b00};
            2'b01:   next_addr = idx_q * StrideA;
            2'b10:   next_addr = {idx_q[ADDR_W-3:0], 2'b00} ^ XOR_MASK;
            default: next_addr = {lfsr_q[ADDR_W-3:0], 2'b00};
        endcase
        next_rw = 1'b0;
        case (rw_mode_q)
            2'b01:   next_rw = 1'b1;
            2'b10:   next_rw = idx_q[0];
            default: next_rw = 1'b0;
        endcase
    end

`ifdef LATENCY_STATS_EN
    logic [CNT_W-1:0]   lat_now;
    logic [2*CNT_W:0]   lat_sum_add;
    assign lat_now     = CNT_W'(to_q) + CNT_W'(1);
    assign lat_sum_add = {1'b0, lat_sum} + {{(CNT_W + 1){1'b0}}, lat_now};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            mode_q        <= '0;
            rw_mode_q     <= '0;
            num_q         <= '0;
            idx_q         <= '0;
            lfsr_q        <= ADDR_W'(1);
            gap_q         <= '0;
            to_q          <= '0;
            cpu_req_valid <= 1'b0;
            cpu_req_rw    <= 1'b0;
            cpu_req_addr  <= '0;
            cpu_req_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            req_cnt       <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
`ifdef LATENCY_STATS_EN
            lat_last      <= '0;
            lat_max       <= '0;
            lat_sum       <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q    <= mode;
                        rw_mode_q <= rw_mode;
                        num_q     <= num_req;
                        req_cnt   <= '0;
                        hit_cnt   <= '0;
                        miss_cnt  <= '0;
                        err       <= 1'b0;
                        idx_q     <= '0;
                        gap_q     <= GapLoad;
                        busy      <= 1'b1;
                        state_q   <= StGap;
`ifdef LATENCY_STATS_EN
                        lat_last  <= '0;
                        lat_max   <= '0;
                        lat_sum   <= '0;
`endif
                    end
                end
                StGap: begin
                    if (gap_q == '0) begin
                        cpu_req_valid <= 1'b1;
                        cpu_req_addr  <= next_addr;
                        cpu_req_rw    <= next_rw;
                        cpu_req_wdata <= next_wdata;
                        lfsr_q        <= lfsr_next;
                        state_q       <= StIssue;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                StIssue: begin
                    if (cpu_req_ready) begin
                        cpu_req_valid <= 1'b0;
                        to_q          <= '0;
                        state_q       <= StWaitResp;
                    end
                end
                StWaitResp: begin
                    if (cpu_resp_valid) begin
                        if (cpu_resp_hit) begin
                            hit_cnt <= (&hit_cnt) ? hit_cnt : hit_cnt + CNT_W'(1);
                        end else begin
                            miss_cnt <= (&miss_cnt) ? miss_cnt : miss_cnt + CNT_W'(1);
                        end
                        req_cnt <= req_cnt_inc;
                        idx_q   <= idx_q + ADDR_W'(1);
`ifdef LATENCY_STATS_EN
                        lat_last <= lat_now;
                        if (lat_now > lat_max) lat_max <= lat_now;
                        lat_sum  <= lat_sum_add[2*CNT_W] ? '1 : lat_sum_add[2*CNT_W-1:0];
`endif
                        if (run_end) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            gap_q   <= GapLoad;
                            state_q <= StGap;
                        end
                    end else if (to_q == ToLast) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                StDone: begin
                    if (!start) begin
                        done    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
